// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and forwarding control for a 5-stage in-order pipeline.
// Tracks EX/MEM/WB shadow copies of in-flight instructions to drive stall and operand selects.
module hazard_fwd_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        isForw_ON,
    input  logic        id_valid,
    input  logic [6:0]  id_op,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        flush,
    output logic        stall,
    output logic [1:0]  forwA,
    output logic [1:0]  forwB,
    output logic [15:0] stall_cnt
);

    localparam logic [6:0] R_TYPE  = 7'b0110011;
    localparam logic [6:0] I_IMM   = 7'b0010011;
    localparam logic [6:0] I_LOAD  = 7'b0000011;
    localparam logic [6:0] S_TYPE  = 7'b0100011;
    localparam logic [6:0] B_TYPE  = 7'b1100011;
    localparam logic [6:0] J_JAL   = 7'b1101111;
    localparam logic [6:0] I_JALR  = 7'b1100111;
    localparam logic [6:0] U_LUI   = 7'b0110111;
    localparam logic [6:0] U_AUIPC = 7'b0010111;

    localparam logic [1:0]  SEL_RF  = 2'b00;
    localparam logic [1:0]  SEL_MEM = 2'b01;
    localparam logic [1:0]  SEL_WB  = 2'b10;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef struct packed {
        logic       valid;
        logic [6:0] op;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       regwrite;
        logic       is_load;
    } stage_t;

    function automatic logic f_uses_rs1(input logic [6:0] op);
        case (op)
            R_TYPE, I_IMM, I_LOAD, S_TYPE, B_TYPE, I_JALR: f_uses_rs1 = 1'b1;
            default:                                       f_uses_rs1 = 1'b0;
        endcase
    endfunction

    function automatic logic f_uses_rs2(input logic [6:0] op);
        case (op)
            R_TYPE, S_TYPE, B_TYPE: f_uses_rs2 = 1'b1;
            default:                f_uses_rs2 = 1'b0;
        endcase
    endfunction

    function automatic logic f_regwrite(input logic [6:0] op);
        case (op)
            R_TYPE, I_IMM, I_LOAD, J_JAL, I_JALR, U_LUI, U_AUIPC: f_regwrite = 1'b1;
            default:                                              f_regwrite = 1'b0;
        endcase
    endfunction

    // A producer in stage s supplies source src only if it really writes a non-x0 register.
    function automatic logic f_match(input stage_t s, input logic [4:0] src, input logic used);
        f_match = used && s.valid && s.regwrite && (s.rd != 5'd0) && (s.rd == src);
    endfunction

    stage_t      r_ex;
    stage_t      r_mem;
    stage_t      r_wb;
    logic [15:0] r_stall_cnt;

    stage_t      w_id_dec;
    logic        w_id_use1;
    logic        w_id_use2;
    logic        w_ex_use1;
    logic        w_ex_use2;
    logic        w_haz_fwd;
    logic        w_haz_ilk;
    logic        w_hazard;
    logic        w_stall;
    logic [1:0]  w_forw_a;
    logic [1:0]  w_forw_b;
    logic        w_unused_fields;

    always_comb begin
        w_id_dec          = '0;
        w_id_dec.valid    = id_valid;
        w_id_dec.op       = id_op;
        w_id_dec.rs1      = id_rs1;
        w_id_dec.rs2      = id_rs2;
        w_id_dec.rd       = id_rd;
        w_id_dec.regwrite = f_regwrite(id_op);
        w_id_dec.is_load  = (id_op == I_LOAD);
    end

    assign w_id_use1 = id_valid && f_uses_rs1(id_op);
    assign w_id_use2 = id_valid && f_uses_rs2(id_op);

    // With forwarding only a load still in EX cannot be bypassed; without it
    // anything in EX or MEM must drain to the write-before-read register file.
    always_comb begin
        w_haz_fwd = r_ex.is_load &&
                    (f_match(r_ex, id_rs1, w_id_use1) || f_match(r_ex, id_rs2, w_id_use2));
        w_haz_ilk = f_match(r_ex,  id_rs1, w_id_use1) || f_match(r_ex,  id_rs2, w_id_use2) ||
                    f_match(r_mem, id_rs1, w_id_use1) || f_match(r_mem, id_rs2, w_id_use2);
        w_hazard  = isForw_ON ? w_haz_fwd : w_haz_ilk;
    end

    assign w_stall = w_hazard && !flush;

    assign w_ex_use1 = r_ex.valid && f_uses_rs1(r_ex.op);
    assign w_ex_use2 = r_ex.valid && f_uses_rs2(r_ex.op);

    // MEM holds the younger result, so it wins over WB.
    always_comb begin
        w_forw_a = SEL_RF;
        w_forw_b = SEL_RF;
        if (isForw_ON) begin
            if (f_match(r_mem, r_ex.rs1, w_ex_use1)) begin
                w_forw_a = SEL_MEM;
            end else if (f_match(r_wb, r_ex.rs1, w_ex_use1)) begin
                w_forw_a = SEL_WB;
            end
            if (f_match(r_mem, r_ex.rs2, w_ex_use2)) begin
                w_forw_b = SEL_MEM;
            end else if (f_match(r_wb, r_ex.rs2, w_ex_use2)) begin
                w_forw_b = SEL_WB;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            if (w_stall || flush) begin
                r_ex <= '0;
            end else begin
                r_ex <= w_id_dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= 16'd0;
        end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    // Fields carried for pipeline visibility but not consumed by this stage's logic.
    assign w_unused_fields = ^{r_mem.rs1, r_mem.rs2, r_mem.is_load,
                               r_wb.op, r_wb.rs1, r_wb.rs2, r_wb.is_load};

    assign stall     = w_stall;
    assign forwA     = w_forw_a;
    assign forwB     = w_forw_b;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: doc/hazard_fwd_ctrl.md
HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have the port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have the port isForw_ON, input, 1 bit: forwarding enable; 0 means interlock-only mode.
REQ-005 The block SHALL have the port id_valid, input, 1 bit: the ID-stage instruction is real (not a bubble).
REQ-006 The block SHALL have the port id_op, input, 7 bits: ID-stage opcode; the encodings are R_TYPE, I_IMM, I_LOAD, S_TYPE, B_TYPE, J_JAL, I_JALR, U_LUI and U_AUIPC from constant_def.vh.
REQ-007 The block SHALL have the ports id_rs1, id_rs2 and id_rd, input, 5 bits each: ID-stage register indices.
REQ-008 The block SHALL have the port flush, input, 1 bit: kill the ID-stage instruction (taken branch or jump).
REQ-009 The block SHALL have the port stall, output, 1 bit: hold PC and IF/ID; insert a bubble into EX.
REQ-010 The block SHALL have the ports forwA and forwB, output, 2 bits each: operand selects for the EX-stage instruction; 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result; 11 is never driven.
REQ-011 The block SHALL have the port stall_cnt, output, 16 bits: count of stall cycles, saturating.

Function
REQ-012 The block SHALL keep three shadow stages: EX, MEM and WB.
- Each stage holds {valid, op, rs1, rs2, rd, regwrite, is_load}.
REQ-013 Decode rules SHALL be as follows.
- uses_rs1 = R, I_IMM, I_LOAD, S, B, JALR.
- uses_rs2 = R, S, B.
- regwrite = R, I_IMM, I_LOAD, JAL, JALR, LUI, AUIPC.
- is_load = I_LOAD.
- Unknown opcodes use nothing and write nothing.
REQ-014 A source SHALL match a stage when all of the following hold.
- The stage is valid.
- The stage has regwrite set.
- The stage rd is not 0.
- The stage rd equals the source index.
- The source is used by the instruction.
- Register x0 never matches.
REQ-015 forwA SHALL be combinational for the EX shadow instruction.
- 01 if the EX rs1 matches the MEM stage.
- Otherwise 10 if it matches the WB stage.
- Otherwise 00.
- MEM has priority over WB.
REQ-016 forwB SHALL follow the same rule as forwA, using EX rs2.
REQ-017 When isForw_ON=0, forwA and forwB SHALL both be 00.
REQ-018 When isForw_ON=1, the hazard condition SHALL be: the ID instruction is valid, and a used ID source matches an EX shadow entry that has is_load=1.
REQ-019 When isForw_ON=0, the hazard condition SHALL be: the ID instruction is valid, and a used ID source matches the EX or MEM shadow entry.
- WB is not a hazard; the register file is write-before-read.
REQ-020 The stall output SHALL equal hazard AND NOT flush, and SHALL be combinational.
REQ-021 On each rising edge when not in reset, the shadow stages SHALL update as follows.
- WB takes MEM, and MEM takes EX.
- EX takes a bubble (valid=0) if stall=1 or flush=1.
- Otherwise EX takes the decoded ID instruction, with valid=id_valid.
REQ-022 The interlock latency SHALL be as follows.
- A load-use pair with forwarding on stalls exactly 1 cycle.
- With forwarding off, a dependent instruction right behind its producer stalls exactly 2 cycles.
- With forwarding off, a dependent instruction one instruction behind its producer stalls exactly 1 cycle.
REQ-023 stall_cnt SHALL increment by 1 on each edge where stall=1, and SHALL saturate at 0xFFFF with no wrap.
REQ-024 When flush and hazard occur in the same cycle, flush SHALL win: no stall, a bubble enters EX, and stall_cnt is unchanged.
REQ-025 A change of isForw_ON SHALL take effect combinationally in the same cycle; the shadow contents SHALL be unaffected.

Reset
REQ-026 On a reset edge, all three shadow stages SHALL become valid=0, and stall_cnt SHALL become 0.
REQ-027 While reset is asserted, stall SHALL be 0 (all stages are invalid after the first reset edge), and forwA and forwB SHALL be 00.
REQ-028 Reset asserted mid-stall SHALL drop the stall in the cycle after the reset edge; in-flight entries SHALL be discarded and not forwarded.

Verification
REQ-029 R-to-R forwarding, forwarding on: feed add x5,x1,x2 then sub x6,x5,x5. When the sub is in EX, forwA=01, forwB=01, and stall stays 0 throughout.
REQ-030 Distance-2 forwarding: feed add x5, then an unrelated nop-like I_IMM to x7, then or x8,x0,x5. When the or is in EX, forwA=00 (rs1=x0) and forwB=10.
REQ-031 Load-use: feed lw x3 then add x4,x3,x1 with forwarding on. stall=1 for exactly 1 cycle, stall_cnt=1, and then forwA=10 when the add is in EX.
REQ-032 Interlock mode: feed add x5 then sw x5,0(x6) with isForw_ON=0. stall=1 for 2 cycles, stall_cnt=2, and forwA/forwB stay 00.
REQ-033 Flush priority and x0: feed lw x0 then add x9,x0,x0 and get no stall. Then feed lw x3 then add x4,x3,x3 with flush=1 on the add cycle: stall=0, a bubble enters EX, and stall_cnt is unchanged.
REQ-034 Saturation and reset: preload stall_cnt to 0xFFFE and create 3 stall cycles. The count reads 0xFFFF and holds. Asserting reset then gives stall_cnt=0 and all stages invalid on the next edge.
